// File: rtl/crc_pkg.sv
// -----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the serial CRC/LFSR engine:
//   - crc_state_t : FSM state encoding (IDLE, CALC, SHIFT, DONE)
//   - CRC_WIDTH_DEF / TAPS_DEF / SEED_DEF : default engine configuration
// -----------------------------------------------------------------------------
package crc_pkg;

    localparam int          CRC_WIDTH_DEF = 8;
    localparam logic [7:0]  TAPS_DEF      = 8'b0100_0100;
    localparam logic [7:0]  SEED_DEF      = 8'hD8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } crc_state_t;

endpackage : crc_pkg

// File: rtl/crc_lfsr_engine_if.sv
// -----------------------------------------------------------------------------
// crc_lfsr_engine_if
// Serial payload in / serial CRC out bundle for crc_lfsr_engine.
//   data_in   : payload bit, LSB first (upstream -> engine)
//   active_in : payload-bit qualifier (upstream -> engine)
//   crc_out   : CRC bit, LSB first (engine -> downstream)
//   crc_valid : crc_out carries a CRC bit
//   busy      : engine is in CALC or SHIFT
//   done      : one-cycle pulse after the last CRC bit
// Handshake: a payload bit is transferred on every rising clk edge where
// active_in=1 and the engine is in IDLE or CALC; there is no ready signal,
// so the upstream must not present a frame while busy is in SHIFT or done
// is high (such bits are dropped). crc_out is meaningful only when
// crc_valid=1 and is forced to 0 otherwise.
// Modports: master = upstream/bench, slave = engine.
// -----------------------------------------------------------------------------
interface crc_lfsr_engine_if;

    logic data_in;
    logic active_in;
    logic crc_out;
    logic crc_valid;
    logic busy;
    logic done;

    modport master (
        output data_in,
        output active_in,
        input  crc_out,
        input  crc_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  active_in,
        output crc_out,
        output crc_valid,
        output busy,
        output done
    );

endinterface : crc_lfsr_engine_if

// File: rtl/crc_lfsr_step.sv
// -----------------------------------------------------------------------------
// crc_lfsr_step
// Combinational single-bit LFSR update (right-shifting Galois form).
//   fb             = data_in ^ crc_in[0]
//   crc_next[W-1]  = fb
//   crc_next[i]    = crc_in[i+1] ^ (TAPS[i] & fb), i < W-1
// Ports:
//   crc_in   [W-1:0] current LFSR value
//   data_in          payload bit
//   crc_next [W-1:0] updated LFSR value
// TAPS[W-1] has no effect: the MSB always takes the feedback bit directly.
// -----------------------------------------------------------------------------
module crc_lfsr_step #(
    parameter int                 W    = 8,
    parameter logic [W-1:0]       TAPS = 8'b0100_0100
) (
    input  logic [W-1:0] crc_in,
    input  logic         data_in,
    output logic [W-1:0] crc_next
);

    logic fb;

    always_comb begin
        fb            = data_in ^ crc_in[0];
        crc_next      = '0;
        crc_next[W-1] = fb;
        for (int i = 0; i < W - 1; i++) begin
            crc_next[i] = crc_in[i+1] ^ (TAPS[i] & fb);
        end
    end

endmodule : crc_lfsr_step

// File: rtl/crc_lfsr_engine.sv
// -----------------------------------------------------------------------------
// crc_lfsr_engine
// Serial CRC engine: absorbs a payload bit stream (LSB first) into an LFSR
// while active_in is high, then serializes the CRC LSB first for CRC_WIDTH
// cycles, pulses done, reloads SEED and returns to IDLE.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        crc_lfsr_engine_if.slave (data_in, active_in, crc_out,
//              crc_valid, busy, done)
//   state_dbg  current FSM state
// Build option:
//   CRC_FINAL_XOR_EN  when defined, the CRC is inverted on the cycle the
//                     engine enters SHIFT, so the serialized value is ~crc.
// -----------------------------------------------------------------------------
module crc_lfsr_engine
    import crc_pkg::*;
#(
    parameter int                   CRC_WIDTH = CRC_WIDTH_DEF,
    parameter logic [CRC_WIDTH-1:0] TAPS      = TAPS_DEF,
    parameter logic [CRC_WIDTH-1:0] SEED      = SEED_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    crc_lfsr_engine_if.slave   bus,
    output crc_state_t         state_dbg
);

    localparam int                CNT_W    = $clog2(CRC_WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(CRC_WIDTH - 1);

    crc_state_t             state_q, state_d;
    logic [CRC_WIDTH-1:0]   crc_q, crc_d, crc_step;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    crc_lfsr_step #(
        .W    (CRC_WIDTH),
        .TAPS (TAPS)
    ) u_step (
        .crc_in   (crc_q),
        .data_in  (bus.data_in),
        .crc_next (crc_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            crc_q   <= SEED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.active_in) begin
                    crc_d   = crc_step;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (bus.active_in) begin
                    crc_d = crc_step;
                end else begin
                    state_d = ST_SHIFT;
`ifdef CRC_FINAL_XOR_EN
                    crc_d = crc_q ^ {CRC_WIDTH{1'b1}};
`endif
                end
            end
            ST_SHIFT: begin
                // crc_q[0] is on crc_out this cycle; expose the next bit.
                crc_d = crc_q >> 1;
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                crc_d   = SEED;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                crc_d   = SEED;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode directly from the state register so an asynchronous
    // reset clears them immediately.
    assign bus.crc_valid = (state_q == ST_SHIFT);
    assign bus.crc_out   = (state_q == ST_SHIFT) & crc_q[0];
    assign bus.busy      = (state_q == ST_CALC) || (state_q == ST_SHIFT);
    assign bus.done      = (state_q == ST_DONE);
    assign state_dbg     = state_q;

endmodule : crc_lfsr_engine

// File: tb/tb_crc_lfsr_engine.sv
// -----------------------------------------------------------------------------
// tb_crc_lfsr_engine
// Two engine instances share clock, reset and stimulus: dut_s uses the
// default SEED (8'hD8), dut_z uses SEED=0. Each frame's expected CRC for
// both instances comes from ref_crc, which walks the payload bits with
// integer arithmetic.
// -----------------------------------------------------------------------------
module tb_crc_lfsr_engine;
    import crc_pkg::*;

    localparam logic [7:0] TAPS_TB = 8'b0100_0100;
    localparam logic [7:0] SEED_S  = 8'hD8;
    localparam logic [7:0] SEED_Z  = 8'h00;

    logic       clk;
    logic       rst_n;
    crc_state_t st_s, st_z;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    bit         frame_q[$];
    logic [7:0] last_s, last_z;

    crc_lfsr_engine_if if_s ();
    crc_lfsr_engine_if if_z ();

    crc_lfsr_engine dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if_s.slave),
        .state_dbg (st_s)
    );

    crc_lfsr_engine #(
        .CRC_WIDTH (8),
        .TAPS      (TAPS_TB),
        .SEED      (SEED_Z)
    ) dut_z (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (if_z.slave),
        .state_dbg (st_z)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_crc(input logic [7:0] seed);
        logic [7:0] c;
        bit         fb;
        c = seed;
        foreach (frame_q[i]) begin
            fb = frame_q[i] ^ c[0];
            c  = (c >> 1) ^ (fb ? (8'h80 | (TAPS_TB & 8'h7F)) : 8'h00);
        end
`ifdef CRC_FINAL_XOR_EN
        c = ~c;
`endif
        return c;
    endfunction

    // ---------------- driver ----------------
    task automatic set_in(input bit act, input bit dat);
        if_s.active_in = act;
        if_s.data_in   = dat;
        if_z.active_in = act;
        if_z.data_in   = dat;
    endtask

    function automatic logic [7:0] outs_s();
        return {4'b0, if_s.crc_out, if_s.crc_valid, if_s.busy, if_s.done};
    endfunction

    function automatic logic [7:0] outs_z();
        return {4'b0, if_z.crc_out, if_z.crc_valid, if_z.busy, if_z.done};
    endfunction

    // Runs frame_q through both engines, collects the serialized CRC and
    // checks handshake timing plus CRC value. With disturb=1 active_in and
    // data_in are randomized during SHIFT and DONE.
    task automatic run_frame(input bit disturb, input string name);
        logic [7:0] got_s, got_z, e_s, e_z;
        int n;
        n = frame_q.size();
        exp_q.push_back(ref_crc(SEED_S));
        exp_q.push_back(ref_crc(SEED_Z));
        got_s = '0;
        got_z = '0;

        @(negedge clk);
        checks++;
        if ({st_s, st_z} !== {ST_IDLE, ST_IDLE}) begin
            failures++;
            $display("FAIL %s idle_before_frame: st_s=%0d st_z=%0d exp=%0d", name, st_s, st_z, ST_IDLE);
        end
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            set_in(1'b1, frame_q[i]);
        end
        @(negedge clk);
        checks++;
        if ({if_s.busy, if_s.crc_valid, if_z.busy, if_z.crc_valid} !== 4'b1010) begin
            failures++;
            $display("FAIL %s calc_flags: s busy/valid=%b%b z busy/valid=%b%b exp 10", name,
                     if_s.busy, if_s.crc_valid, if_z.busy, if_z.crc_valid);
        end
        set_in(1'b0, 1'($urandom));

        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            checks++;
            if ({if_s.crc_valid, if_s.busy, if_s.done, if_z.crc_valid, if_z.busy, if_z.done} !== 6'b110110) begin
                failures++;
                $display("FAIL %s shift_flags bit%0d: s=%b z=%b exp 1,1,0", name, b,
                         {if_s.crc_valid, if_s.busy, if_s.done}, {if_z.crc_valid, if_z.busy, if_z.done});
            end
            got_s[b] = if_s.crc_out;
            got_z[b] = if_z.crc_out;
            if (disturb) set_in(1'($urandom), 1'($urandom));
        end

        @(negedge clk);
        checks++;
        if (outs_s() !== 8'h01 || outs_z() !== 8'h01) begin
            failures++;
            $display("FAIL %s done_pulse: s out/valid/busy/done=%b z=%b exp 0001", name,
                     outs_s()[3:0], outs_z()[3:0]);
        end
        if (disturb) set_in(1'b1, 1'($urandom));

        e_s = exp_q.pop_front();
        e_z = exp_q.pop_front();
        checks++;
        if (got_s !== e_s) begin
            failures++;
            $display("FAIL %s crc_seed_d8: got=%h exp=%h len=%0d", name, got_s, e_s, n);
        end
        checks++;
        if (got_z !== e_z) begin
            failures++;
            $display("FAIL %s crc_seed_00: got=%h exp=%h len=%0d", name, got_z, e_z, n);
        end
        last_s = got_s;
        last_z = got_z;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (outs_s() !== 8'h00 || outs_z() !== 8'h00 || st_s !== ST_IDLE || st_z !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_held: s=%b z=%b st_s=%0d st_z=%0d exp all 0", outs_s()[3:0], outs_z()[3:0], st_s, st_z);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (outs_s() !== 8'h00 || outs_z() !== 8'h00 || st_s !== ST_IDLE || st_z !== ST_IDLE) begin
                failures++;
                $display("FAIL reset_idle cyc%0d: s=%b z=%b st_s=%0d st_z=%0d exp all 0", c,
                         outs_s()[3:0], outs_z()[3:0], st_s, st_z);
            end
        end
    endtask

    task automatic test_one_bit();
        logic [7:0] want;
        frame_q = {1'b1};
        run_frame(1'b0, "one_bit");
        want = 8'hC4;
`ifdef CRC_FINAL_XOR_EN
        want = ~want;
`endif
        checks++;
        if (last_z !== want) begin
            failures++;
            $display("FAIL one_bit_c4: got=%h exp=%h", last_z, want);
        end
    endtask

    task automatic test_zero_byte();
        logic [7:0] want;
        frame_q = {};
        for (int i = 0; i < 8; i++) frame_q.push_back(1'b0);
        run_frame(1'b0, "zero_byte");
        want = 8'h00;
`ifdef CRC_FINAL_XOR_EN
        want = ~want;
`endif
        checks++;
        if (last_z !== want) begin
            failures++;
            $display("FAIL zero_byte_crc: got=%h exp=%h", last_z, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] first;
        logic [7:0] payload;
        payload = 8'hA5;
        frame_q = {};
        for (int i = 0; i < 8; i++) frame_q.push_back(payload[i]);
        run_frame(1'b0, "a5_first");
        first = last_s;
        run_frame(1'b0, "a5_second");
        checks++;
        if (last_s !== first) begin
            failures++;
            $display("FAIL a5_repeat: got=%h exp=%h", last_s, first);
        end
    endtask

    task automatic test_reset_mid_shift();
        frame_q = {};
        for (int i = 0; i < 5; i++) frame_q.push_back(1'($urandom));
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            set_in(1'b1, frame_q[i]);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0);
        repeat (4) @(negedge clk);   // SHIFT bit 3 now on crc_out
        checks++;
        if ({if_s.crc_valid, if_z.crc_valid} !== 2'b11) begin
            failures++;
            $display("FAIL rst_shift_pre: valid s=%b z=%b exp 11", if_s.crc_valid, if_z.crc_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs_s() !== 8'h00 || outs_z() !== 8'h00 || st_s !== ST_IDLE || st_z !== ST_IDLE) begin
            failures++;
            $display("FAIL rst_shift_abort: s=%b z=%b st_s=%0d st_z=%0d exp all 0",
                     outs_s()[3:0], outs_z()[3:0], st_s, st_z);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if ({if_s.done, if_z.done} !== 2'b00) begin
                failures++;
                $display("FAIL rst_shift_no_done cyc%0d: s=%b z=%b exp 00", c, if_s.done, if_z.done);
            end
        end
        frame_q = {};
        for (int i = 0; i < 8; i++) frame_q.push_back(1'($urandom));
        run_frame(1'b0, "after_reset");
    endtask

    task automatic test_disturb();
        logic [7:0] calm_s, calm_z;
        frame_q = {};
        for (int i = 0; i < 12; i++) frame_q.push_back(1'($urandom));
        run_frame(1'b0, "calm");
        calm_s = last_s;
        calm_z = last_z;
        run_frame(1'b1, "disturbed");
        checks++;
        if (last_s !== calm_s || last_z !== calm_z) begin
            failures++;
            $display("FAIL disturb_same: got=%h/%h exp=%h/%h", last_s, last_z, calm_s, calm_z);
        end
        // frame after a disturbed DONE must still start from SEED
        run_frame(1'b0, "post_disturb");
    endtask

    task automatic test_random();
        int len;
        for (int f = 0; f < 10; f++) begin
            len = (f == 9) ? 300 : int'($urandom_range(1, 40));
            frame_q = {};
            for (int i = 0; i < len; i++) frame_q.push_back(1'($urandom));
            run_frame(1'b0, "random");
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 1'b0);
        test_reset();
        test_one_bit();
        test_zero_byte();
        test_back_to_back();
        test_reset_mid_shift();
        test_disturb();
        test_random();
        @(negedge clk);
        set_in(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_crc_lfsr_engine

// File: doc/crc_lfsr_engine.md
CRC_LFSR_ENGINE -- requirements
Module: crc_lfsr_engine

Interface
REQ-001 Parameter CRC_WIDTH, 8, LFSR width in bits.
REQ-002 Parameter TAPS, 8'b0100_0100, XOR tap mask applied with the feedback bit.
REQ-003 Parameter SEED, 8'hD8, LFSR value after reset and after each frame.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 data_in  input  1  serial payload bit, LSB first; sampled only while active_in=1.
REQ-007 active_in  input  1  payload-bit qualifier from the upstream serializer.
REQ-008 crc_out  output  1  serial CRC bit, LSB first.
REQ-009 crc_valid  output  1  high while crc_out carries a CRC bit.
REQ-010 busy  output  1  high in CALC and SHIFT states.
REQ-011 done  output  1  single-cycle pulse after the last CRC bit.

Function
REQ-012 The FSM SHALL have states IDLE, CALC, SHIFT, DONE.
REQ-013 Feedback SHALL be fb = data_in XOR crc[0]; crc_next[W-1] = fb; crc_next[i] = crc[i+1] XOR (TAPS[i] AND fb) for i < W-1.
REQ-014 IDLE: active_in=1 -> apply one LFSR update, go to CALC; otherwise hold.
REQ-015 CALC: active_in=1 -> one LFSR update per cycle; active_in=0 -> go to SHIFT, no update.
REQ-016 SHIFT: crc_valid=1, crc_out=crc[0]; crc shifts right by one (MSB filled with 0) each cycle; bit counter counts 0..W-1.
REQ-017 SHIFT SHALL last exactly CRC_WIDTH cycles, then go to DONE.
REQ-018 DONE: done=1 for one cycle, crc reloaded to SEED, counter cleared, go to IDLE.
REQ-019 active_in during SHIFT or DONE SHALL be ignored; no payload bits are consumed.
REQ-020 First bit of a new frame SHALL be accepted in IDLE on the cycle after DONE.
REQ-021 A one-bit frame (active_in high for a single cycle) SHALL be legal.
REQ-022 Frame length SHALL be unbounded; the LFSR carries no length limit.
REQ-023 crc_out SHALL be 0 whenever crc_valid=0.
REQ-024 The bit counter SHALL be $clog2(CRC_WIDTH)+1 bits and SHALL never wrap inside SHIFT.

Reset
REQ-025 rst_n low SHALL force IDLE, crc=SEED, counter=0, crc_valid=0, crc_out=0, busy=0, done=0.
REQ-026 Reset asserted mid-CALC or mid-SHIFT SHALL abort the frame with no done pulse.

Configuration
REQ-027 Macro CRC_FINAL_XOR_EN defined: on the SHIFT entry cycle crc SHALL be XORed with all-ones before serialization.
REQ-028 Macro CRC_FINAL_XOR_EN undefined: the raw LFSR value SHALL be serialized; no XOR logic SHALL be present.

Structure
REQ-029 Package crc_pkg SHALL hold the state enum typedef and default CRC_WIDTH/TAPS/SEED constants.
REQ-030 Sub-module crc_lfsr_step (combinational one-bit LFSR update) SHALL be instantiated once.

Verification
REQ-031 Reset release, no activity for 20 cycles -> outputs all 0, state IDLE.
REQ-032 SEED=0, one-bit frame with data_in=1 -> crc 8'hC4; crc_out sequence 0,0,1,0,0,0,1,1 with crc_valid high 8 cycles; then done pulse.
REQ-033 SEED=0, eight 0 bits -> crc_out all 0 for 8 valid cycles; done one cycle after the last bit.
REQ-034 Default SEED, payload 8'hA5 LSB first -> serialized CRC matches the bench reference model; a second frame back-to-back after DONE gives the identical CRC.
REQ-035 rst_n pulsed low during SHIFT bit 3 -> crc_valid drops immediately, no done pulse, next frame CRC correct.
REQ-036 active_in toggled during SHIFT -> CRC output unchanged versus the undisturbed run.
